// File: rtl/cambus_pkg.sv
// Camera bus word layout shared by the capture FIFO and its neighbours.
package cambus_pkg;

    localparam int unsigned CAMBUS_W         = 14;
    localparam int unsigned CAMBUS_HSYNC_BIT = 13;
    localparam int unsigned CAMBUS_VSYNC_BIT = 12;
    localparam int unsigned CAMBUS_PIX_MSB   = 11;

    typedef struct packed {
        logic                    hsync;
        logic                    vsync;
        logic [CAMBUS_PIX_MSB:0] pixel;
    } cambus_word_t;

endpackage

// File: rtl/cambus_fifo_if.sv
// Handshake bundle between the camera bus writer, the FIFO and the line reader.
// usedw is present only when CAMBUS_FIFO_USEDW_EN is defined.
interface cambus_fifo_if
    import cambus_pkg::*;
#(
    parameter int unsigned WIDTH = CAMBUS_W,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             wrfull;
    logic             rdreq;
    logic             rdempty;
    logic [WIDTH-1:0] q;
`ifdef CAMBUS_FIFO_USEDW_EN
    logic [AW:0]      usedw;
`endif

    modport master (
`ifdef CAMBUS_FIFO_USEDW_EN
        input  usedw,
`endif
        output wrreq, data, rdreq,
        input  wrfull, rdempty, q
    );

    modport slave (
`ifdef CAMBUS_FIFO_USEDW_EN
        output usedw,
`endif
        input  wrreq, data, rdreq,
        output wrfull, rdempty, q
    );

endinterface

// File: rtl/cambus_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Only the read register is reset; storage contents survive reset.
module cambus_fifo_ram
    import cambus_pkg::*;
#(
    parameter int unsigned WIDTH = CAMBUS_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/cambus_fifo.sv
// Single-clock non-showahead FIFO for camera bus words ({hsync, vsync, pixel}).
// Optional occupancy output: define CAMBUS_FIFO_USEDW_EN.
module cambus_fifo
    import cambus_pkg::*;
#(
    parameter int unsigned WIDTH = CAMBUS_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cambus_fifo_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          wr_ok, rd_ok;

    // Flags come from registered cnt only, so full+both favours the read and
    // empty+both favours the write without any extra arbitration.
    assign bus.wrfull  = (cnt == FULL_CNT);
    assign bus.rdempty = (cnt == '0);
    assign wr_ok       = bus.wrreq & ~bus.wrfull;
    assign rd_ok       = bus.rdreq & ~bus.rdempty;

`ifdef CAMBUS_FIFO_USEDW_EN
    assign bus.usedw = cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    cambus_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wp),
        .wdata (bus.data),
        .re    (rd_ok),
        .raddr (rp),
        .q     (bus.q)
    );

endmodule

// File: tb/tb_cambus_fifo.sv
// Scoreboard bench for cambus_fifo: queue-based reference model, directed plus random traffic.
module tb_cambus_fifo;

    localparam int unsigned WIDTH = 14;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [WIDTH-1:0] q;
        bit               empty;
        bit               full;
        int unsigned      used;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    cambus_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cambus_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] q_hold;
    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // One clock cycle of stimulus: drive at negedge, update model, queue expected post-edge state.
    task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r);
        exp_t e;
        bit   wa, ra;
        bus.wrreq = w;
        bus.data  = d;
        bus.rdreq = r;
        wa = w && (model.size() < DEPTH);
        ra = r && (model.size() > 0);
        if (ra) q_hold = model.pop_front();
        if (wa) model.push_back(d);
        e.q     = q_hold;
        e.empty = (model.size() == 0);
        e.full  = (model.size() == DEPTH);
        e.used  = model.size();
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares the DUT against each queued expectation just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("q",       bus.q,       e.q);
                check("rdempty", bus.rdempty, e.empty);
                check("wrfull",  bus.wrfull,  e.full);
`ifdef CAMBUS_FIFO_USEDW_EN
                check("usedw",   bus.usedw,   e.used);
`endif
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_rdempty"}, bus.rdempty, 1);
        check({tag, "_wrfull"},  bus.wrfull,  0);
        check({tag, "_q"},       bus.q,       0);
`ifdef CAMBUS_FIFO_USEDW_EN
        check({tag, "_usedw"},   bus.usedw,   0);
`endif
    endtask

    initial begin
        bus.wrreq = 1'b0;
        bus.rdreq = 1'b0;
        bus.data  = '0;
        q_hold    = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) cyc(0, '0, 0);

        // Single word through, then read on the empty FIFO
        cyc(1, 14'h2ABC, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 0);
        cyc(0, '0, 1);

        // Fill, overflow attempt, full with both requests, drain, underflow attempt
        for (int i = 0; i < 16; i++) cyc(1, WIDTH'(i), 0);
        cyc(1, 14'h3FFF, 0);
        cyc(1, 14'h1111, 1);
        for (int i = 0; i < 15; i++) cyc(0, '0, 1);
        cyc(0, '0, 1);

        // Empty with both requests: write wins, read ignored
        cyc(1, 14'h0555, 1);
        cyc(0, '0, 1);
        cyc(0, '0, 0);

        // Streaming with both requests high, wrapping the pointers many times
        cyc(1, 14'h0000 + WIDTH'($urandom_range(0, 16383)), 0);
        for (int i = 1; i < 100; i++) cyc(1, WIDTH'($urandom_range(0, 16383)), 1);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1);

        // Random traffic, biased each phase towards filling or draining
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 80; i++) begin
                bit w, r;
                w = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 8 : 3));
                r = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 8));
                cyc(w, WIDTH'($urandom_range(0, 16383)), r);
            end
        end

        // Asynchronous reset with five words stored
        while (model.size() > 0) cyc(0, '0, 1);
        for (int i = 0; i < 5; i++) cyc(1, WIDTH'(14'h0100 + i), 0);
        bus.wrreq = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model.delete();
        q_hold = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, '0, 1);
        cyc(1, 14'h1ABC, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 0);

        @(negedge clk);
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cambus_fifo.md
# cambus_fifo

Single-clock synchronous FIFO that buffers camera bus words ({hsync, vsync, pixel[11:0]}) between camera bus capture and the line reader state machine. The writer pushes one word per cycle unless the FIFO is full. The reader pops with a one-cycle read latency (non-showahead). Camera-clock sampling and synchronisation happen upstream; this block sees only `clk`.

## Interface
- WIDTH, 14, word width; bit 13 = hsync, bit 12 = vsync, bits 11:0 = pixel
- DEPTH, 16, number of entries; must be a power of two ≥ 4
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- wrreq  input  1  push `data` this cycle; ignored while `wrfull`=1
- data  input  WIDTH  word to push
- wrfull  output  1  FIFO holds DEPTH words
- rdreq  input  1  pop one word this cycle; ignored while `rdempty`=1
- rdempty  output  1  FIFO holds 0 words
- q  output  WIDTH  registered read data
- usedw  output  $clog2(DEPTH)+1  occupancy (only with CAMBUS_FIFO_USEDW_EN)

## Operation
- Storage: DEPTH-entry RAM, write pointer wp, read pointer rp, each $clog2(DEPTH) bits, both wrap modulo DEPTH. Occupancy count cnt has $clog2(DEPTH)+1 bits.
- Accepted write: wrreq & !wrfull. mem[wp] <= data, wp <= wp+1.
- Accepted read: rdreq & !rdempty. q <= mem[rp], rp <= rp+1.
- cnt changes by +1 for an accepted write alone and by −1 for an accepted read alone. Both accepted in the same cycle leaves cnt unchanged.
- Both requests are gated on the flags as they stand at the start of the cycle:
  - Full with wrreq & rdreq: the read is accepted, the write is dropped.
  - Empty with wrreq & rdreq: the write is accepted, the read is ignored.
- Rejected requests have no effect: no pointer or count change, `q` unchanged, no error output.
- `q` holds its last value whenever no read is accepted.
- wrfull = (cnt == DEPTH); rdempty = (cnt == 0). Both are combinational from registered cnt only, never from the current request inputs.
- Reset (rst_n=0, asynchronous): wp=rp=0, cnt=0, q=0, so rdempty=1 and wrfull=0. RAM contents are not cleared. Reset mid-operation discards all stored words immediately.

## Timing
- Write at edge N: rdempty falls after edge N, i.e. visible in cycle N+1. Earliest read of that word is at edge N+1, with q valid in cycle N+2.
- Read latency is 1: rdreq sampled at edge N, q valid from just after edge N until the next accepted read.
- Back-to-back reads: rdreq held high yields one new word per cycle while not empty.
- The flags update on the same edge as cnt; there are no extra pipeline stages.
- Sustained throughput: one write and one read per cycle.

## Configuration
- CAMBUS_FIFO_USEDW_EN:
  - Defined: the `usedw` port exists and equals cnt.
  - Undefined: the port is absent. Core behaviour is identical.

## Structure
- Package `cambus_pkg`:
  - CAMBUS_W = 14
  - bit-position constants CAMBUS_HSYNC_BIT = 13, CAMBUS_VSYNC_BIT = 12, CAMBUS_PIX_MSB = 11
  - packed struct `cambus_word_t` {hsync, vsync, pixel[11:0]}
- Sub-module `cambus_fifo_ram`: simple dual-port RAM with one write port, one registered read port and a read enable. It supplies `q`. Pointer, count and flag logic stay in `cambus_fifo`.

## Test plan
- Reset then idle: rdempty=1, wrfull=0, q=0, usedw=0. Assert rst_n=0 mid-stream with 5 words stored: flags return to empty and full-low immediately, without waiting for a clock edge.
- Write 0x2ABC, then read next cycle: rdempty=0 in the cycle after the write; q=0x2ABC the cycle after rdreq; rdempty=1 afterwards.
- Fill 16 words 0x0000..0x000F with no reads: wrfull=1 after the 16th. A 17th write of 0x3FFF is dropped. Reading 16 returns 0x0000..0x000F in order, then rdempty=1.
- Full with simultaneous wrreq (0x1111) and rdreq: the oldest word is read, 0x1111 is dropped, and wrfull falls (usedw=15).
- Empty with simultaneous wrreq (0x0555) and rdreq: the read is ignored and q unchanged; 0x0555 is stored and returned by the next read.
- Streaming of 100 words with wrreq and rdreq both continuously high after the first write: output sequence equals the input sequence, and pointers wrap past index 15 without loss.
